// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters: predicts at Fetch, trains and flags mispredicts at Execute.
// Lookup and recovery are combinational; training, invalidation and statistics land on the next clk edge; no backpressure.
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   PCF,
    output logic              PredTakenF,
    output logic [XLEN-1:0]   PredTargetF,
    input  logic              UpdValidE,
    input  logic              UpdJumpE,
    input  logic [XLEN-1:0]   UpdPCE,
    input  logic              UpdTakenE,
    input  logic [XLEN-1:0]   UpdTargetE,
    input  logic              PredTakenE,
    input  logic [XLEN-1:0]   PredTargetE,
    output logic              MispredictE,
    output logic [XLEN-1:0]   RecoverPCE,
    input  logic              InvalidateAll,
    output logic [STAT_W-1:0] BranchCnt,
    output logic [STAT_W-1:0] MispredCnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - 2 - IDX_W;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_W'(1);

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [XLEN-1:0]    tgt_q [ENTRIES];
    logic [CNT_W-1:0]   cnt_q [ENTRIES];

    logic [STAT_W-1:0]  branch_cnt_q, branch_cnt_d;
    logic [STAT_W-1:0]  mispred_cnt_q, mispred_cnt_d;

    logic [IDX_W-1:0]   f_idx;
    logic [TAG_W-1:0]   f_tag;
    logic               f_hit;

    logic [IDX_W-1:0]   e_idx;
    logic [TAG_W-1:0]   e_tag;
    logic               e_hit;
    logic               e_taken;

    logic               wr_en;
    logic [XLEN-1:0]    tgt_d;
    logic [CNT_W-1:0]   cnt_d;

    assign f_idx = PCF[IDX_W+1:2];
    assign f_tag = PCF[XLEN-1:IDX_W+2];
    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

    assign PredTakenF  = f_hit && cnt_q[f_idx][CNT_W-1];
    assign PredTargetF = PredTakenF ? tgt_q[f_idx] : PCF + XLEN'(4);

    assign e_idx   = UpdPCE[IDX_W+1:2];
    assign e_tag   = UpdPCE[XLEN-1:IDX_W+2];
    assign e_hit   = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    assign e_taken = UpdTakenE || UpdJumpE;

    assign MispredictE = UpdValidE &&
                         ((PredTakenE != e_taken) || (e_taken && (PredTargetE != UpdTargetE)));
    assign RecoverPCE  = e_taken ? UpdTargetE : UpdPCE + XLEN'(4);

    // A miss on a not-taken branch leaves the BTB alone so it does not evict a useful entry.
    always_comb begin
        wr_en = 1'b0;
        tgt_d = tgt_q[e_idx];
        cnt_d = cnt_q[e_idx];
        if (UpdValidE) begin
            if (e_hit) begin
                wr_en = 1'b1;
                if (UpdJumpE) begin
                    cnt_d = CNT_MAX;
                    tgt_d = UpdTargetE;
                end else if (e_taken) begin
                    cnt_d = (cnt_q[e_idx] == CNT_MAX) ? CNT_MAX : cnt_q[e_idx] + CNT_W'(1);
                    tgt_d = UpdTargetE;
                end else begin
                    cnt_d = (cnt_q[e_idx] == '0) ? '0 : cnt_q[e_idx] - CNT_W'(1);
                end
            end else if (e_taken) begin
                wr_en = 1'b1;
                tgt_d = UpdTargetE;
                cnt_d = UpdJumpE ? CNT_MAX : CNT_WT;
            end
        end
    end

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (UpdValidE) begin
            if (branch_cnt_q != '1) begin
                branch_cnt_d = branch_cnt_q + STAT_W'(1);
            end
            if (MispredictE && (mispred_cnt_q != '1)) begin
                mispred_cnt_d = mispred_cnt_q + STAT_W'(1);
            end
        end
    end

    // Tag/target/counter writes still land under InvalidateAll; only the valid bit is suppressed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                cnt_q[i] <= CNT_WNT;
            end
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (InvalidateAll) begin
                valid_q <= '0;
            end else if (wr_en) begin
                valid_q[e_idx] <= 1'b1;
            end
            if (wr_en) begin
                tag_q[e_idx] <= e_tag;
                tgt_q[e_idx] <= tgt_d;
                cnt_q[e_idx] <= cnt_d;
            end
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign BranchCnt  = branch_cnt_q;
    assign MispredCnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench: stimulus queues expected outputs, a negedge monitor pops and compares them.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PCF;
    logic        UpdValidE, UpdJumpE, UpdTakenE, PredTakenE, InvalidateAll;
    logic [31:0] UpdPCE, UpdTargetE, PredTargetE;

    logic        PredTakenF, MispredictE;
    logic [31:0] PredTargetF, RecoverPCE, BranchCnt, MispredCnt;

    logic        unused_pt4, unused_mis4;
    logic [31:0] unused_ptgt4, unused_rec4;
    logic [3:0]  BranchCnt4, MispredCnt4;

    branch_predictor #(.XLEN(32), .ENTRIES(16), .CNT_W(2), .STAT_W(32)) dut (
        .clk(clk), .reset(reset), .PCF(PCF),
        .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
        .UpdValidE(UpdValidE), .UpdJumpE(UpdJumpE), .UpdPCE(UpdPCE),
        .UpdTakenE(UpdTakenE), .UpdTargetE(UpdTargetE),
        .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
        .MispredictE(MispredictE), .RecoverPCE(RecoverPCE),
        .InvalidateAll(InvalidateAll),
        .BranchCnt(BranchCnt), .MispredCnt(MispredCnt)
    );

    branch_predictor #(.XLEN(32), .ENTRIES(16), .CNT_W(2), .STAT_W(4)) dut4 (
        .clk(clk), .reset(reset), .PCF(PCF),
        .PredTakenF(unused_pt4), .PredTargetF(unused_ptgt4),
        .UpdValidE(UpdValidE), .UpdJumpE(UpdJumpE), .UpdPCE(UpdPCE),
        .UpdTakenE(UpdTakenE), .UpdTargetE(UpdTargetE),
        .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
        .MispredictE(unused_mis4), .RecoverPCE(unused_rec4),
        .InvalidateAll(InvalidateAll),
        .BranchCnt(BranchCnt4), .MispredCnt(MispredCnt4)
    );

    always #5 clk = ~clk;

    localparam int S_PT = 0, S_PTGT = 1, S_MIS = 2, S_REC = 3, S_BC = 4, S_MC = 5, S_BC4 = 6, S_MC4 = 7;

    typedef struct {
        string       name;
        int          sig;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic expect_v(input string name, input int sig, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.sig  = sig;
        e.val  = val;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] actual(input int sig);
        case (sig)
            S_PT:    return {31'd0, PredTakenF};
            S_PTGT:  return PredTargetF;
            S_MIS:   return {31'd0, MispredictE};
            S_REC:   return RecoverPCE;
            S_BC:    return BranchCnt;
            S_MC:    return MispredCnt;
            S_BC4:   return {28'd0, BranchCnt4};
            S_MC4:   return {28'd0, MispredCnt4};
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t        e;
            logic [31:0] a;
            e = sb.pop_front();
            a = actual(e.sig);
            checks++;
            if (a !== e.val) begin
                errors++;
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", e.name, a, e.val, $time);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        UpdValidE     = 1'b0;
        UpdJumpE      = 1'b0;
        UpdTakenE     = 1'b0;
        UpdPCE        = 32'h0;
        UpdTargetE    = 32'h0;
        PredTakenE    = 1'b0;
        PredTargetE   = 32'h0;
        InvalidateAll = 1'b0;
    endtask

    task automatic upd(input logic jump, input logic [31:0] pc, input logic taken,
                       input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
        UpdValidE   = 1'b1;
        UpdJumpE    = jump;
        UpdPCE      = pc;
        UpdTakenE   = taken;
        UpdTargetE  = tgt;
        PredTakenE  = pt;
        PredTargetE = ptgt;
    endtask

    task automatic look(input string name, input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
        PCF = pc;
        expect_v({name, "_pt"}, S_PT, {31'd0, pt});
        expect_v({name, "_ptgt"}, S_PTGT, tgt);
    endtask

    task automatic exe(input string name, input logic mis, input logic [31:0] rec);
        expect_v({name, "_mis"}, S_MIS, {31'd0, mis});
        expect_v({name, "_rec"}, S_REC, rec);
    endtask

    task automatic stats(input string name, input logic [31:0] bc, input logic [31:0] mc);
        expect_v({name, "_bc"}, S_BC, bc);
        expect_v({name, "_mc"}, S_MC, mc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        PCF   = 32'h100;
        next_cycle();
        look("rst", 32'h100, 1'b0, 32'h104);
        stats("rst", 0, 0);

        next_cycle();
        reset = 1'b0;
        // Taken branch predicted not-taken: allocate weakly taken.
        upd(1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        look("c1", 32'h100, 1'b0, 32'h104);
        exe("c1", 1'b1, 32'h80);
        stats("c1", 0, 0);

        next_cycle();
        look("c2", 32'h100, 1'b1, 32'h80);
        stats("c2", 1, 1);
        upd(1'b0, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        exe("c2", 1'b1, 32'h104);

        next_cycle();
        look("c3", 32'h100, 1'b0, 32'h104);
        upd(1'b0, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
        exe("c3", 1'b0, 32'h104);

        next_cycle();
        look("c4", 32'h100, 1'b0, 32'h104);
        upd(1'b0, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
        exe("c4", 1'b0, 32'h104);

        // Counter climbs 00 -> 01 -> 10 -> 11 -> 11.
        next_cycle();
        look("c5", 32'h100, 1'b0, 32'h104);
        upd(1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        exe("c5", 1'b1, 32'h80);
        next_cycle();
        look("c6", 32'h100, 1'b0, 32'h104);
        upd(1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        exe("c6", 1'b1, 32'h80);
        next_cycle();
        look("c7", 32'h100, 1'b1, 32'h80);
        upd(1'b0, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        exe("c7", 1'b0, 32'h80);
        next_cycle();
        look("c8", 32'h100, 1'b1, 32'h80);
        upd(1'b0, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        exe("c8", 1'b0, 32'h80);

        next_cycle();
        look("c9", 32'h100, 1'b1, 32'h80);
        stats("c9", 8, 4);
        upd(1'b0, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        exe("c9", 1'b1, 32'h104);

        // Still taken after one decrement proves 11 saturated instead of wrapping.
        next_cycle();
        look("c10", 32'h100, 1'b1, 32'h80);
        stats("c10", 9, 5);
        upd(1'b0, 32'h140, 1'b1, 32'h200, 1'b0, 32'h144);
        exe("c10", 1'b1, 32'h200);

        next_cycle();
        look("alias_old", 32'h100, 1'b0, 32'h104);
        next_cycle();
        look("alias_new", 32'h140, 1'b1, 32'h200);
        upd(1'b1, 32'h20, 1'b0, 32'h400, 1'b0, 32'h24);
        exe("jal_alloc", 1'b1, 32'h400);

        next_cycle();
        look("jal_hit", 32'h20, 1'b1, 32'h400);
        upd(1'b0, 32'h20, 1'b0, 32'h400, 1'b1, 32'h400);
        exe("dec_strong", 1'b1, 32'h24);

        next_cycle();
        look("strong", 32'h20, 1'b1, 32'h400);
        upd(1'b1, 32'h20, 1'b1, 32'h400, 1'b1, 32'h3FC);
        exe("jal_tgt", 1'b1, 32'h400);

        next_cycle();
        look("pre_inv", 32'h20, 1'b1, 32'h400);
        stats("pre_inv", 13, 9);
        upd(1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        InvalidateAll = 1'b1;
        exe("inv_upd", 1'b1, 32'h80);

        next_cycle();
        look("inv_a", 32'h100, 1'b0, 32'h104);
        stats("inv", 14, 10);
        next_cycle();
        look("inv_b", 32'h20, 1'b0, 32'h24);
        expect_v("bc4_pre", S_BC4, 14);
        expect_v("mc4_pre", S_MC4, 10);

        for (int i = 0; i < 8; i++) begin
            next_cycle();
            upd(1'b0, 32'h300, 1'b0, 32'h0, 1'b1, 32'h500);
            exe("sat_loop", 1'b1, 32'h304);
        end

        next_cycle();
        stats("sat32", 22, 18);
        expect_v("bc4_sat", S_BC4, 15);
        expect_v("mc4_sat", S_MC4, 15);
        upd(1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);

        next_cycle();
        look("pre_rst", 32'h100, 1'b1, 32'h80);
        stats("pre_rst", 23, 19);

        // Reset raised between edges must clear state before the next rising edge.
        next_cycle();
        reset = 1'b1;
        look("mid_rst", 32'h100, 1'b0, 32'h104);
        stats("mid_rst", 0, 0);
        expect_v("bc4_rst", S_BC4, 0);
        upd(1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        exe("rst_mis", 1'b1, 32'h80);

        next_cycle();
        reset = 1'b0;
        look("post_rst", 32'h100, 1'b0, 32'h104);
        stats("post_rst", 0, 0);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
